// File: rtl/nco2_sched.sv
// Two-channel NCO scheduler. Both phase accumulators share one sine ROM,
// serviced in alternating slots (S0 for channel 0, S1 for channel 1).
// Lookup address is registered in the slot; the sample strobe follows one edge later.

module nco2_sched #(
    parameter int unsigned PHASE_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         ch_en,
    input  logic               ftw_valid,
    input  logic               ftw_ch,
    input  logic [PHASE_W-1:0] ftw_data,
    input  logic               ftw_sync,
    output logic               ftw_ready,
    output logic [3:0]         rom_addr,
    input  logic [7:0]         rom_data,
    output logic               smp_valid,
    output logic               smp_ch,
    output logic [7:0]         smp_data,
    output logic               smp_wrap
);

    typedef enum logic [1:0] {StIdle, StS0, StS1} state_t;

    state_t             state;
    logic [PHASE_W-1:0] acc0, acc1;
    logic [PHASE_W-1:0] ftw0, ftw1;
    logic               pv, pch, pwrap;

    logic [PHASE_W:0]   sum0, sum1;
    logic               wr0, wr1;

    // Next-phase sums with carry, write acceptance and the write handshake
    always_comb begin
        sum0      = {1'b0, acc0} + {1'b0, ftw0};
        sum1      = {1'b0, acc1} + {1'b0, ftw1};
        // A channel's tuning word cannot be loaded during its own slot
        ftw_ready = ~rst & ~(((state == StS0) & ~ftw_ch) | ((state == StS1) & ftw_ch));
        wr0       = ftw_valid & ftw_ready & ~ftw_ch;
        wr1       = ftw_valid & ftw_ready & ftw_ch;
    end

    // Slot FSM, accumulators, tuning words and the pending lookup flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            acc0     <= '0;
            acc1     <= '0;
            ftw0     <= '0;
            ftw1     <= '0;
            rom_addr <= '0;
            pv       <= 1'b0;
            pch      <= 1'b0;
            pwrap    <= 1'b0;
        end else begin
            // Writes never target the channel owning the current slot, so a
            // sync clear cannot collide with that channel's accumulate below
            if (wr0) begin
                ftw0 <= ftw_data;
                if (ftw_sync) acc0 <= '0;
            end
            if (wr1) begin
                ftw1 <= ftw_data;
                if (ftw_sync) acc1 <= '0;
            end

            case (state)
                StIdle: begin
                    pv <= 1'b0;
                    if (|ch_en) state <= StS0;
                end
                StS0: begin
                    // S0 always hands over to S1 so channel 1 keeps its slot
                    state <= StS1;
                    if (ch_en[0]) begin
                        rom_addr <= acc0[PHASE_W-1 -: 4];
                        acc0     <= sum0[PHASE_W-1:0];
                        pwrap    <= sum0[PHASE_W];
                        pv       <= 1'b1;
                        pch      <= 1'b0;
                    end else begin
                        pv <= 1'b0;
                    end
                end
                StS1: begin
                    state <= (|ch_en) ? StS0 : StIdle;
                    if (ch_en[1]) begin
                        rom_addr <= acc1[PHASE_W-1 -: 4];
                        acc1     <= sum1[PHASE_W-1:0];
                        pwrap    <= sum1[PHASE_W];
                        pv       <= 1'b1;
                        pch      <= 1'b1;
                    end else begin
                        pv <= 1'b0;
                    end
                end
                default: begin
                    state <= StIdle;
                    pv    <= 1'b0;
                end
            endcase
        end
    end

    // Output stage: capture the ROM word one edge after its address was registered
    always_ff @(posedge clk) begin
        if (rst) begin
            smp_valid <= 1'b0;
            smp_ch    <= 1'b0;
            smp_data  <= '0;
            smp_wrap  <= 1'b0;
        end else begin
            smp_valid <= pv;
            smp_ch    <= pch;
            smp_wrap  <= pwrap & pv;
            if (pv) smp_data <= rom_data;
        end
    end

endmodule
